// File: rtl/input_debouncer.sv
// input_debouncer: two-flop synchroniser followed by a four-state stability
// FSM. A raw level change is accepted only after the synchronised input has
// held the new level for DEBOUNCE_CYCLES+1 consecutive samples. The module
// produces the clean level `a`, one-cycle rise/fall strobes and a busy flag.
// Every output is registered and is updated on the same edge as the state.

module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic a,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
);

    // The counter only ever needs to reach N-1. The extra bit keeps the
    // width at least 1 when N is 1.
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] IDLE_LOW  = 2'd0;
    localparam logic [1:0] WAIT_HIGH = 2'd1;
    localparam logic [1:0] IDLE_HIGH = 2'd2;
    localparam logic [1:0] WAIT_LOW  = 2'd3;

    logic             s1_r;
    logic             s2_r;
    logic [1:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             a_r;
    logic             rise_r;
    logic             fall_r;
    logic             busy_r;

    logic [1:0]       next_state_s;
    logic [CNT_W-1:0] next_cnt_s;
    logic             next_a_s;
    logic             next_rise_s;
    logic             next_fall_s;
    logic             next_busy_s;

    // Two-flop synchroniser. Nothing sits between s1 and s2, and the FSM reads only s2.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
        end else begin
            s1_r <= btn_in;
            s2_r <= s1_r;
        end
    end

    // Next state and next counter value for the stability qualifier.
    always_comb begin
        next_state_s = state_r;
        next_cnt_s   = cnt_r;
        case (state_r)
            IDLE_LOW: begin
                if (s2_r) begin
                    next_state_s = WAIT_HIGH;
                    next_cnt_s   = CNT_ZERO;
                end else begin
                    next_state_s = IDLE_LOW;
                end
            end
            WAIT_HIGH: begin
                if (!s2_r) begin
                    next_state_s = IDLE_LOW;
                    next_cnt_s   = CNT_ZERO;
                end else if (cnt_r >= CNT_LAST) begin
                    next_state_s = IDLE_HIGH;
                    next_cnt_s   = CNT_ZERO;
                end else begin
                    next_cnt_s   = cnt_r + CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                if (!s2_r) begin
                    next_state_s = WAIT_LOW;
                    next_cnt_s   = CNT_ZERO;
                end else begin
                    next_state_s = IDLE_HIGH;
                end
            end
            WAIT_LOW: begin
                if (s2_r) begin
                    next_state_s = IDLE_HIGH;
                    next_cnt_s   = CNT_ZERO;
                end else if (cnt_r >= CNT_LAST) begin
                    next_state_s = IDLE_LOW;
                    next_cnt_s   = CNT_ZERO;
                end else begin
                    next_cnt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                // An unreachable encoding recovers to the safe low level.
                next_state_s = IDLE_LOW;
                next_cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Next output values are decoded from the transition so that they land
    // on the same edge as the state update.
    always_comb begin
        next_a_s    = (next_state_s == IDLE_HIGH) || (next_state_s == WAIT_LOW);
        next_busy_s = (next_state_s == WAIT_HIGH) || (next_state_s == WAIT_LOW);
        next_rise_s = (state_r == WAIT_HIGH) && (next_state_s == IDLE_HIGH);
        next_fall_s = (state_r == WAIT_LOW)  && (next_state_s == IDLE_LOW);
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE_LOW;
            cnt_r   <= CNT_ZERO;
            a_r     <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= next_cnt_s;
            a_r     <= next_a_s;
            rise_r  <= next_rise_s;
            fall_r  <= next_fall_s;
            busy_r  <= next_busy_s;
        end
    end

    assign a          = a_r;
    assign rise_pulse = rise_r;
    assign fall_pulse = fall_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_input_debouncer.sv
// Testbench for input_debouncer (N = 4). The reference model tracks the
// delayed input and the length of the current run of samples that differ
// from the accepted level. A run of N+1 samples flips the level.

module tb_input_debouncer;

    localparam int N = 4;

    logic clk;
    logic reset;
    logic btn_in;
    logic a;
    logic rise_pulse;
    logic fall_pulse;
    logic busy;

    int checks;
    int errors;

    // Reference model state.
    logic m_s1;
    logic m_s2;
    logic m_a;
    logic m_rise;
    logic m_fall;
    int   m_run;

    // Tallies of the pulses the DUT produces.
    int rise_cnt;
    int fall_cnt;
    int same_twice;
    int last_pulse;   // 0 none, 1 rise, 2 fall

    input_debouncer #(.DEBOUNCE_CYCLES(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_in     (btn_in),
        .a          (a),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1   = 1'b0;
        m_s2   = 1'b0;
        m_a    = 1'b0;
        m_rise = 1'b0;
        m_fall = 1'b0;
        m_run  = 0;
    endtask

    // Drive one input value, take one rising edge, advance the model and
    // compare every output at the following falling edge.
    task automatic step(input logic b);
        logic samp;
        btn_in = b;
        @(posedge clk);
        samp   = m_s2;
        m_s2   = m_s1;
        m_s1   = b;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (samp != m_a) begin
            m_run = m_run + 1;
            if (m_run == N + 1) begin
                m_a    = samp;
                m_run  = 0;
                m_rise = samp;
                m_fall = ~samp;
            end
        end else begin
            m_run = 0;
        end
        @(negedge clk);
        check_value("a",    {31'd0, a},          {31'd0, m_a});
        check_value("rise", {31'd0, rise_pulse}, {31'd0, m_rise});
        check_value("fall", {31'd0, fall_pulse}, {31'd0, m_fall});
        check_value("busy", {31'd0, busy},       {31'd0, (m_run != 0)});
        if (rise_pulse === 1'b1) begin
            rise_cnt = rise_cnt + 1;
            if (last_pulse == 1) same_twice = same_twice + 1;
            last_pulse = 1;
        end
        if (fall_pulse === 1'b1) begin
            fall_cnt = fall_cnt + 1;
            if (last_pulse == 2) same_twice = same_twice + 1;
            last_pulse = 2;
        end
    endtask

    task automatic clear_tallies();
        rise_cnt   = 0;
        fall_cnt   = 0;
        same_twice = 0;
        last_pulse = 0;
    endtask

    // Hold b and return the number of edges until `a` equals b (bounded).
    task automatic edges_until(input logic b, output int n);
        n = -1;
        for (int i = 1; i <= 30; i++) begin
            step(b);
            if (a === b) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;
        clear_tallies();
        model_reset();
        btn_in = 1'b0;
        reset  = 1'b1;
        #2 reset = 1'b0;
        #1;
        check_value("rst_a",    {31'd0, a},          32'd0);
        check_value("rst_rise", {31'd0, rise_pulse}, 32'd0);
        check_value("rst_fall", {31'd0, fall_pulse}, 32'd0);
        check_value("rst_busy", {31'd0, busy},       32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Quiet input after reset.
        for (int i = 0; i < 20; i++) step(1'b0);

        // Clean press: the level follows N+3 edges after the change.
        edges_until(1'b1, n);
        check_value("press_latency", n, N + 3);
        for (int i = 0; i < 10; i++) step(1'b1);
        edges_until(1'b0, n);
        check_value("release_latency", n, N + 3);
        for (int i = 0; i < 10; i++) step(1'b0);

        // A glitch of N samples is rejected.
        clear_tallies();
        for (int i = 0; i < N; i++) step(1'b1);
        for (int i = 0; i < 12; i++) step(1'b0);
        check_value("glitch_n_rise", rise_cnt, 0);
        check_value("glitch_n_a", {31'd0, a}, 32'd0);

        // N+1 samples is accepted.
        clear_tallies();
        for (int i = 0; i < N + 1; i++) step(1'b1);
        for (int i = 0; i < 3; i++) step(1'b0);
        check_value("glitch_n1_rise", rise_cnt, 1);
        check_value("glitch_n1_a", {31'd0, a}, 32'd1);
        for (int i = 0; i < 3; i++) step(1'b1);
        for (int i = 0; i < 10; i++) step(1'b1);

        // Bounce down from a=1, then stable low.
        clear_tallies();
        step(1'b1); step(1'b0); step(1'b1); step(1'b0); step(1'b0); step(1'b1);
        edges_until(1'b0, n);
        check_value("bounce_latency", n, N + 3);
        for (int i = 0; i < 5; i++) step(1'b0);
        check_value("bounce_fall", fall_cnt, 1);

        // Asynchronous reset while qualifying a press.
        for (int i = 0; i < 3; i++) step(1'b1);
        check_value("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check_value("arst_a",    {31'd0, a},          32'd0);
        check_value("arst_busy", {31'd0, busy},       32'd0);
        check_value("arst_rise", {31'd0, rise_pulse}, 32'd0);
        check_value("arst_fall", {31'd0, fall_pulse}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_value("arst_hold_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        model_reset();
        clear_tallies();
        edges_until(1'b1, n);
        check_value("post_rst_latency", n, N + 3);
        check_value("post_rst_rise", {31'd0, rise_pulse}, 32'd1);
        for (int i = 0; i < 10; i++) step(1'b1);
        for (int i = 0; i < 15; i++) step(1'b0);

        // Back-to-back qualified presses.
        clear_tallies();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 10; i++) step(1'b1);
            for (int i = 0; i < 10; i++) step(1'b0);
        end
        for (int i = 0; i < 10; i++) step(1'b0);
        check_value("b2b_rise", rise_cnt, 3);
        check_value("b2b_fall", fall_cnt, 3);
        check_value("b2b_alternate", same_twice, 0);

        // Random runs of varying length.
        clear_tallies();
        for (int r = 0; r < 300; r++) begin
            logic lvl;
            int   len;
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 2 * N + 2);
            for (int i = 0; i < len; i++) step(lvl);
        end
        check_value("rand_alternate", same_twice, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
